// File: rtl/boolean_truth_table_sweeper.sv
// ============================================================================
// Module  : boolean_truth_table_sweeper
// Brief   : Sweeps every x vector into a boolean DUT and checks y against a
//           parameterised truth table; reports pass, error count, first error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module boolean_truth_table_sweeper #(
    parameter int                  N_IN      = 3,
    parameter logic [2**N_IN-1:0]  EXP_TABLE = 8'b1001_0110,
    parameter int                  DUT_LAT   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] dut_x,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_err_vld,
    output logic [N_IN-1:0] first_err_idx
);

    localparam logic [N_IN-1:0] c_last_idx = '1;
    localparam logic [3:0]      c_lat_max  = 4'(DUT_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [N_IN-1:0] r_dut_x;
    logic [3:0]      r_lat_cnt;
    logic [N_IN:0]   r_err_cnt;
    logic            r_first_err_vld;
    logic [N_IN-1:0] r_first_err_idx;
    logic            r_pass;

    logic            w_start_acc;
    logic            w_sample;
    logic            w_mismatch;
    logic            w_last;
    logic [N_IN:0]   w_err_final;

    // abort suppresses the compare of the cycle it is seen in
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_sample    = (r_state == ST_APPLY) && !abort && (r_lat_cnt == c_lat_max);
    assign w_mismatch  = w_sample && (dut_y != EXP_TABLE[r_dut_x]);
    assign w_last      = (r_dut_x == c_last_idx);
    assign w_err_final = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_APPLY;
            ST_APPLY: begin
                if (abort)                  w_state_next = ST_IDLE;
                else if (w_sample && w_last) w_state_next = ST_DONE;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dut_x         <= '0;
            r_lat_cnt       <= '0;
            r_err_cnt       <= '0;
            r_first_err_vld <= 1'b0;
            r_first_err_idx <= '0;
            r_pass          <= 1'b0;
        end else if (w_start_acc) begin
            r_dut_x         <= '0;
            r_lat_cnt       <= '0;
            r_err_cnt       <= '0;
            r_first_err_vld <= 1'b0;
            r_first_err_idx <= '0;
            r_pass          <= 1'b0;
        end else if (r_state == ST_APPLY && !abort) begin
            if (w_sample) begin
                r_lat_cnt <= '0;
                r_err_cnt <= w_err_final;
                if (w_mismatch && !r_first_err_vld) begin
                    r_first_err_vld <= 1'b1;
                    r_first_err_idx <= r_dut_x;
                end
                // the last vector stays on dut_x; the next start rewinds it
                if (w_last) begin
                    r_pass <= (w_err_final == '0);
                end else begin
                    r_dut_x <= r_dut_x + 1'b1;
                end
            end else begin
                r_lat_cnt <= r_lat_cnt + 4'd1;
            end
        end
    end

    assign dut_x         = r_dut_x;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_vld = r_first_err_vld;
    assign first_err_idx = r_first_err_idx;

endmodule

`default_nettype wire
